// File: rtl/tmds_ddr_serializer.sv
// TMDS DDR serializer: takes one 10-bit symbol per data lane per pixel and
// shifts it out two bits per bit-clock (rising/falling halves) for DDR
// output cells, alongside a matching TMDS clock lane. Idle control symbols
// fill any slot where no word is ready, and the whole link is held quiet
// while the PLL is not locked.
//
// Handshake: a word on in_data is transferred on every rising clk edge where
// in_valid and in_ready are both 1. in_ready does not depend on in_valid, and
// in_data is ignored on any edge where in_ready is 0.
module tmds_ddr_serializer #(
    parameter int         CHANNELS    = 3,
    parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic [CHANNELS*10-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CHANNELS-1:0]     out_rise,
    output logic [CHANNELS-1:0]     out_fall,
    output logic                    clk_rise,
    output logic                    clk_fall,
    output logic                    running,
    output logic                    underflow,
    input  logic                    underflow_clear
);

    // Clock lane: five bit-times low then five high, LSB first.
    localparam logic [9:0] CLK_PATTERN = 10'b1111100000;

    logic                   r_sync1;
    logic                   r_sync2;
    logic [2:0]             r_phase;
    logic [CHANNELS*10-1:0] r_sr;
    logic [9:0]             r_clk_sr;
    logic [CHANNELS*10-1:0] r_buf;
    logic                   r_buf_full;
    logic                   r_primed;
    logic                   r_underflow;

    logic [CHANNELS*10-1:0] w_sr_shifted;
    logic                   w_phase_last;
    logic                   w_accept;
    logic                   w_uf_set;

    assign w_phase_last = (r_phase == 3'd4);
    assign in_ready     = r_sync2 & (~r_buf_full | w_phase_last);
    assign w_accept     = in_valid & in_ready;
    // Starvation only counts while the link stays up across this edge.
    assign w_uf_set     = r_sync1 & r_sync2 & w_phase_last & ~r_buf_full & r_primed;

    assign running   = r_sync2;
    assign underflow = r_underflow;
    assign clk_rise  = r_clk_sr[0];
    assign clk_fall  = r_clk_sr[1];

    // Per-lane right shift by two and tap of the two DDR bits.
    always_comb begin
        w_sr_shifted = '0;
        out_rise     = '0;
        out_fall     = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            w_sr_shifted[n*10 +: 10] = {2'b00, r_sr[n*10+2 +: 8]};
            out_rise[n]              = r_sr[n*10];
            out_fall[n]              = r_sr[n*10+1];
        end
    end

    // Two-flop synchronizer bringing the PLL lock into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // Phase counter, shift registers and one-entry holding buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= 3'd0;
            r_sr       <= '0;
            r_clk_sr   <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_primed   <= 1'b0;
        end else if (!r_sync1) begin
            // Lock lost (or never gained): drop everything, partial word included.
            r_phase    <= 3'd0;
            r_sr       <= '0;
            r_clk_sr   <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_primed   <= 1'b0;
        end else if (!r_sync2) begin
            // Edge where running rises: the first running cycle already shows idle.
            r_phase    <= 3'd0;
            r_sr       <= {CHANNELS{IDLE_SYMBOL}};
            r_clk_sr   <= CLK_PATTERN;
            r_buf_full <= 1'b0;
            r_primed   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf    <= in_data;
                r_primed <= 1'b1;
            end
            if (w_phase_last) begin
                r_phase    <= 3'd0;
                r_sr       <= r_buf_full ? r_buf : {CHANNELS{IDLE_SYMBOL}};
                r_clk_sr   <= CLK_PATTERN;
                r_buf_full <= w_accept;
            end else begin
                r_phase  <= r_phase + 3'd1;
                r_sr     <= w_sr_shifted;
                r_clk_sr <= {2'b00, r_clk_sr[9:2]};
                if (w_accept) begin
                    r_buf_full <= 1'b1;
                end
            end
        end
    end

    // Sticky underflow flag; a set on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (underflow_clear) begin
            r_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// Bench for tmds_ddr_serializer: directed scenarios plus a random run, all
// compared against a symbol-level reference model kept in this file.
module tb_tmds_ddr_serializer;

  localparam int         CH   = 3;
  localparam int         W    = CH * 10;
  localparam int         OW   = 2 * CH + 5;
  localparam logic [9:0] IDLE = 10'b1101010100;

  // clock / reset block
  logic clk = 1'b0;
  logic reset_n;
  logic pll_locked;
  logic [W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [CH-1:0] out_rise;
  logic [CH-1:0] out_fall;
  logic clk_rise;
  logic clk_fall;
  logic running;
  logic underflow;
  logic underflow_clear;

  always #4 clk = ~clk;

  tmds_ddr_serializer #(.CHANNELS(CH), .IDLE_SYMBOL(IDLE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_rise(out_rise),
    .out_fall(out_fall),
    .clk_rise(clk_rise),
    .clk_fall(clk_fall),
    .running(running),
    .underflow(underflow),
    .underflow_clear(underflow_clear)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // reference model: tracks the symbol on the wire and its bit-time index
  bit m_l1 = 1'b0;
  bit m_run = 1'b0;
  bit m_pend = 1'b0;
  bit m_primed = 1'b0;
  bit m_uf = 1'b0;
  bit m_sym_word = 1'b0;
  int m_cycle = 0;
  logic [W-1:0] m_sym = '0;
  logic [W-1:0] m_pword = '0;

  task automatic model_step();
    int ph;
    bit ready;
    bit acc;
    bit uf_set;
    if (!reset_n) begin
      m_l1 = 0; m_run = 0; m_cycle = 0; m_sym = '0; m_pword = '0;
      m_pend = 0; m_primed = 0; m_uf = 0; m_sym_word = 0;
      return;
    end
    ph = m_cycle % 5;
    ready = m_run && (!m_pend || ph == 4);
    acc = ready && (in_valid === 1'b1);
    uf_set = 0;
    if (!m_l1) begin
      m_run = 0; m_cycle = 0; m_sym = '0; m_pend = 0; m_primed = 0; m_sym_word = 0;
    end else if (!m_run) begin
      m_run = 1; m_cycle = 0; m_sym = {CH{IDLE}}; m_sym_word = 0; m_pend = 0; m_primed = 0;
    end else begin
      if (ph == 4) begin
        if (m_pend) begin
          m_sym = m_pword;
          m_sym_word = 1;
        end else begin
          m_sym = {CH{IDLE}};
          m_sym_word = 0;
          uf_set = m_primed;
        end
        m_pend = acc;
      end else if (acc) begin
        m_pend = 1;
      end
      if (acc) begin
        m_pword = in_data;
        m_primed = 1;
      end
      m_cycle++;
    end
    if (uf_set) m_uf = 1;
    else if (underflow_clear === 1'b1) m_uf = 0;
    m_l1 = pll_locked;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  int e_ph;
  logic [CH-1:0] e_rise;
  logic [CH-1:0] e_fall;
  logic e_clk_rise;
  logic e_clk_fall;
  logic e_ready;
  logic [OW-1:0] e_all;
  logic [OW-1:0] obs;

  always_comb begin
    e_ph = m_cycle % 5;
    e_rise = '0;
    e_fall = '0;
    for (int n = 0; n < CH; n++) begin
      e_rise[n] = m_sym[n*10 + 2*e_ph];
      e_fall[n] = m_sym[n*10 + 2*e_ph + 1];
    end
    e_clk_rise = m_run && (e_ph >= 3);
    e_clk_fall = m_run && (e_ph >= 2);
    e_ready = m_run && (!m_pend || e_ph == 4);
    e_all = {e_rise, e_fall, e_clk_rise, e_clk_fall, e_ready, m_run, m_uf};
  end

  assign obs = {out_rise, out_fall, clk_rise, clk_fall, in_ready, running, underflow};

  // driver tasks / scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    pll_locked = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    underflow_clear = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", obs, {OW{1'b0}});
    end
    vectors++;
    if (obs !== e_all) begin
      miscompares++;
      $display("FAIL reset_model: got %h expected %h", obs, e_all);
    end
  endtask

  task automatic test_startup();
    logic [4:0] r_tab;
    logic [4:0] f_tab;
    logic [4:0] cr_tab;
    logic [4:0] cf_tab;
    r_tab = 5'b11110;
    f_tab = 5'b10000;
    cr_tab = 5'b11000;
    cf_tab = 5'b11100;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (running !== 1'b0) begin
      miscompares++;
      $display("FAIL startup_latency1: running got %b expected 0", running);
    end
    @(negedge clk);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL startup_latency2: running got %b expected 1", running);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({out_rise, out_fall, clk_rise, clk_fall, underflow} !==
          {{CH{r_tab[k]}}, {CH{f_tab[k]}}, cr_tab[k], cf_tab[k], 1'b0}) begin
        miscompares++;
        $display("FAIL startup_idle ph%0d: got %b_%b_%b%b uf%b expected %b_%b_%b%b uf0",
                 k, out_rise, out_fall, clk_rise, clk_fall, underflow,
                 {CH{r_tab[k]}}, {CH{f_tab[k]}}, cr_tab[k], cf_tab[k]);
      end
      vectors++;
      if (obs !== e_all) begin
        miscompares++;
        $display("FAIL startup_model ph%0d: got %h expected %h", k, obs, e_all);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_word();
    for (int i = 0; i < 10 && e_ph != 1; i++) @(negedge clk);
    vectors++;
    if (e_ph != 1) begin
      miscompares++;
      $display("FAIL single_wait_ph1: phase got %0d expected 1", e_ph);
    end
    in_data = {10'h155, 10'h000, 10'h3FF};
    in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 12 && !(e_ph == 0 && m_sym_word); i++) @(negedge clk);
    vectors++;
    if (!(e_ph == 0 && m_sym_word)) begin
      miscompares++;
      $display("FAIL single_wait_reload: phase got %0d word %0d expected phase 0 word 1", e_ph, m_sym_word);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({out_rise, out_fall} !== {3'b101, 3'b001}) begin
        miscompares++;
        $display("FAIL single_word ph%0d: got %b_%b expected 101_001", k, out_rise, out_fall);
      end
      vectors++;
      if (obs !== e_all) begin
        miscompares++;
        $display("FAIL single_model ph%0d: got %h expected %h", k, obs, e_all);
      end
      @(negedge clk);
    end
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL single_underflow: got %b expected 1", underflow);
    end
    vectors++;
    if ({out_rise, out_fall} !== 6'b000000) begin
      miscompares++;
      $display("FAIL single_idle_after: got %b_%b expected 000_000", out_rise, out_fall);
    end
  endtask

  task automatic test_underflow_clear();
    for (int i = 0; i < 10 && e_ph != 1; i++) @(negedge clk);
    underflow_clear = 1'b1;
    @(negedge clk);
    underflow_clear = 1'b0;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_clear_plain: got %b expected 0", underflow);
    end
    for (int i = 0; i < 10 && e_ph != 4; i++) @(negedge clk);
    underflow_clear = 1'b1;
    @(negedge clk);
    underflow_clear = 1'b0;
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL uf_set_wins: got %b expected 1", underflow);
    end
    for (int i = 0; i < 10 && e_ph != 1; i++) @(negedge clk);
    underflow_clear = 1'b1;
    @(negedge clk);
    underflow_clear = 1'b0;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_clear_later: got %b expected 0", underflow);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int ready_cnt;
    int words_checked;
    bit acc;
    logic [W-1:0] asm_sym;
    logic [W-1:0] want;
    base = $urandom_range(0, 900);
    ready_cnt = 0;
    words_checked = 0;
    asm_sym = '0;
    for (int n = 0; n < CH; n++) in_data[n*10 +: 10] = 10'(base + n);
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      vectors++;
      if (obs !== e_all) begin
        miscompares++;
        $display("FAIL b2b_model cyc%0d: got %h expected %h", i, obs, e_all);
      end
      if (i >= 10 && in_ready === 1'b1) ready_cnt++;
      for (int n = 0; n < CH; n++) begin
        asm_sym[n*10 + 2*e_ph] = out_rise[n];
        asm_sym[n*10 + 2*e_ph + 1] = out_fall[n];
      end
      if (e_ph == 4 && m_sym_word) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_scoreboard cyc%0d: got %h with no word expected", i, asm_sym);
        end else begin
          want = exp_q.pop_front();
          words_checked++;
          if (asm_sym !== want) begin
            miscompares++;
            $display("FAIL b2b_scoreboard cyc%0d: got %h expected %h", i, asm_sym, want);
          end
        end
      end
      acc = e_ready;
      if (acc) exp_q.push_back(in_data);
      @(posedge clk);
      #1;
      if (acc) begin
        base += CH;
        for (int n = 0; n < CH; n++) in_data[n*10 +: 10] = 10'(base + n);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (ready_cnt != 10) begin
      miscompares++;
      $display("FAIL b2b_ready_rate: got %0d expected 10", ready_cnt);
    end
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_underflow: got %b expected 0", underflow);
    end
    vectors++;
    if (words_checked < 10) begin
      miscompares++;
      $display("FAIL b2b_word_count: got %0d expected >=10", words_checked);
    end
    exp_q.delete();
  endtask

  task automatic test_lock_loss();
    bit saved_uf;
    for (int i = 0; i < 10 && e_ph != 0; i++) @(negedge clk);
    in_data = W'($urandom());
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && e_ph != 2; i++) @(negedge clk);
    pll_locked = 1'b0;
    saved_uf = m_uf;
    @(negedge clk);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_loss_delay: running got %b expected 1", running);
    end
    @(negedge clk);
    vectors++;
    if (obs !== {{(OW-1){1'b0}}, saved_uf}) begin
      miscompares++;
      $display("FAIL lock_loss_quiet: got %h expected %h", obs, {{(OW-1){1'b0}}, saved_uf});
    end
    underflow_clear = 1'b1;
    @(negedge clk);
    underflow_clear = 1'b0;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_loss_clear: got %b expected 0", underflow);
    end
    pll_locked = 1'b1;
    @(negedge clk);
    vectors++;
    if (running !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_latency1: got %b expected 0", running);
    end
    @(negedge clk);
    vectors++;
    if ({running, out_rise, out_fall, clk_rise, clk_fall} !== {1'b1, {(2*CH+2){1'b0}}}) begin
      miscompares++;
      $display("FAIL relock_idle_ph0: got %b_%b_%b_%b%b expected 1_000_000_00",
               running, out_rise, out_fall, clk_rise, clk_fall);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (obs !== e_all) begin
        miscompares++;
        $display("FAIL relock_model cyc%0d: got %h expected %h", i, obs, e_all);
      end
      @(negedge clk);
    end
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_unprimed: underflow got %b expected 0", underflow);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10 && e_ph != 0; i++) @(negedge clk);
    in_data = W'($urandom());
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && e_ph != 2; i++) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs, {OW{1'b0}});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_recover: running got %b expected 1", running);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      vectors++;
      if (obs !== e_all) begin
        miscompares++;
        $display("FAIL random_model cyc%0d: got %h expected %h", i, obs, e_all);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = W'($urandom());
      underflow_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
      @(negedge clk);
    end
    in_valid = 1'b0;
    underflow_clear = 1'b0;
    pll_locked = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_single_word();
    test_underflow_clear();
    test_back_to_back();
    test_lock_loss();
    test_async_reset();
    test_random();
    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tmds_ddr_serializer.md
Name: tmds_ddr_serializer

Overview:
- Consumes the 125 MHz clock and lock output of the HDMI PLL (25 MHz pixel rate, 5× bit clock with DDR output = 250 Mb/s per lane).
- Accepts one 10-bit TMDS symbol per data channel per pixel via valid/ready, and emits 2 bits per clock per lane for DDR output cells.
- Also generates the TMDS clock lane.
- Inserts an idle control symbol when starved, and holds the link quiet while the PLL is unlocked.

Parameters:
- CHANNELS, 3, number of TMDS data lanes.
- IDLE_SYMBOL, 10'b1101010100, symbol sent when no word is available (TMDS control, C1C0=00).

Ports:
- clk  input  1  125 MHz bit clock from PLL.
- reset_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL lock, asynchronous to clk.
- in_data  input  CHANNELS*10  symbols; lane n = bits [10n+9:10n].
- in_valid  input  1  in_data valid.
- in_ready  output  1  word accepted on edge where in_valid&in_ready.
- out_rise  output  CHANNELS  bit for rising-edge DDR half, per lane.
- out_fall  output  CHANNELS  bit for falling-edge DDR half, per lane.
- clk_rise  output  1  TMDS clock lane, rising half.
- clk_fall  output  1  TMDS clock lane, falling half.
- running  output  1  synchronized lock; serializer active.
- underflow  output  1  sticky: idle symbol inserted after stream primed.
- underflow_clear  input  1  clears underflow.

Behaviour:
- Reset (async, reset_n low): all flops 0. Outputs in_ready=0, out_*=0, clk_*=0, running=0, underflow=0. The release edge is synchronous.
- Lock synchronizer: pll_locked passes through a 2-flop sync; running = 2nd flop.
  - Latency: 2 clocks from pll_locked rise to running=1.
- Not running:
  - phase=0, holding buffer empty, primed=0, shift registers 0.
  - in_ready=0, all out_*/clk_* = 0.
  - underflow is held, not set.
- Phase counter: 0..4, increments each running cycle and wraps 4→0.
  - On the first running cycle, phase=0 and the shift regs already hold IDLE_SYMBOL / clock pattern, loaded on the running 0→1 edge.
- Per-lane 10-bit shift register sr:
  - out_rise[n] = sr_n[0], out_fall[n] = sr_n[1].
  - Each edge with phase≠4: sr shifts right by 2.
  - Edge with phase==4 (reload): sr ← buffer if full, else IDLE_SYMBOL.
  - Transmit order is LSB first; bit 2k is the rising half of phase k.
- Clock lane:
  - Separate 10-bit register reloaded with 10'b1111100000 at each reload; same shifting.
  - clk_rise/clk_fall per phase 0..4: (0,0) (0,0) (0,1) (1,1) (1,1).
- One-entry holding buffer:
  - in_ready = running & (!buf_full | phase==4).
  - Accept with buffer empty, phase≠4: buf ← in_data, full.
  - Reload edge: buffer drains to sr; a simultaneous accept refills it, otherwise it goes empty.
  - Back-to-back stream at 1 word / 5 clocks: no idle insertion.
  - Accept-to-first-bit latency: 1–5 clocks, depending on phase.
- primed: set on the first accept while running; cleared when not running.
- underflow:
  - Set on a reload edge with buffer empty while primed=1.
  - underflow_clear clears it; if set and clear coincide, set wins.
  - Sticky across lock loss; cleared only by clear or reset.
- Lock loss mid-word: takes effect 2 clocks later (synchronizer).
  - That cycle: sr/buffer/phase cleared and outputs 0. The partial word is dropped; no underflow.
- Any in_data while in_ready=0 is ignored.

Test Plan:
- Reset held, pll_locked=1 → all outputs 0. Release → running=1 after 2 clocks; first 5 cycles out_rise/out_fall on every lane = (0,0)(1,0)(1,0)(1,0)(1,1) (IDLE 10'b1101010100 LSB-first); clk pairs as specified; underflow=0.
- Lane0 = 10'h3FF, lane1 = 10'h000, lane2 = 10'h155 accepted once → after next reload, lane0 outputs (1,1)×5, lane1 (0,0)×5, lane2 (1,0)×5; the following reload sends IDLE and sets underflow=1.
- Continuous in_valid=1 with incrementing words → in_ready pulses once per 5 clocks after the buffer fills; the serial stream reassembles each word exactly; underflow stays 0.
- Drive pll_locked=0 at phase 2 of a word → 2 clocks later all outputs 0, in_ready=0, underflow unchanged. Re-lock → restarts with IDLE at phase 0, primed=0.
- underflow_clear asserted on the same edge as an underflow reload → underflow=1. Clear on a later cycle with no reload → underflow=0.
- Assert reset_n low between edges mid-word → outputs 0 immediately (async), not waiting for a clock.
